bp_run_ctrl: RTL and testbench

PDU run-control stage that sits directly downstream of the breakpoint list register. It consumes the head breakpoint (bp_0, bp_valid[0]) and produces the reach_bp pop pulse that feeds back into the list. It drives the CPU global enable for run, stop and single-step commands from the PDU command decoder. It also records the halt PC, halt cause and per-run cycle/instruction counts for readback.

---
 rtl/bp_run_ctrl_pkg.sv | 17 +
 rtl/bp_sat_counter.sv | 28 ++
 rtl/bp_run_ctrl.sv | 138 +++++++++++++
 tb/tb_bp_run_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bp_run_ctrl_pkg.sv
// Shared PDU run-control definitions: run-state encodings and halt-cause codes.
package bp_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RS_HALT = 2'd0,
        RS_RUN  = 2'd1,
        RS_STEP = 2'd2
    } run_state_t;

    typedef enum logic [1:0] {
        HC_NONE = 2'd0,
        HC_BP   = 2'd1,
        HC_STOP = 2'd2,
        HC_STEP = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module bp_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + ONE;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/bp_run_ctrl.sv
// PDU run control: run/step/stop FSM driving cpu_en, head-breakpoint match and
// pop pulse, halt PC/cause capture and per-run cycle/instruction counters.
module bp_run_ctrl
    import bp_run_ctrl_pkg::*;
#(
    parameter int STEP_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_stop,
    input  logic             cpu_commit,
    input  logic [31:0]      cpu_pc,
    input  logic [31:0]      bp_0,
    input  logic [2:0]       bp_valid,
    output logic             cpu_en,
    output logic             reach_bp,
    output logic [1:0]       run_state,
    output logic [31:0]      halt_pc,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);

    localparam int              TMR_W    = $clog2(STEP_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    run_state_t       state_reg, state_next;
    halt_cause_t      cause_reg, cause_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic             cpu_en_reg;
    logic             reach_bp_reg;
    logic [31:0]      halt_pc_reg;
    logic             start;
    logic             commit_v;
    logic             hit;
    logic             unused_bits;

    // Only the head entry of the list is examined here.
    assign unused_bits = ^bp_valid[2:1];

    assign commit_v = cpu_commit & cpu_en_reg;
    assign hit      = commit_v & bp_valid[0] & (cpu_pc == bp_0);

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        tmr_next   = tmr_reg;
        start      = 1'b0;
        case (state_reg)
            RS_HALT: begin
                if (cmd_run) begin
                    state_next = RS_RUN;
                    start      = 1'b1;
                end else if (cmd_step) begin
                    state_next = RS_STEP;
                    start      = 1'b1;
                end
                if (start) begin
                    cause_next = HC_NONE;
                    tmr_next   = TMR_LOAD;
                end
            end
            RS_RUN: begin
                if (hit) begin
                    state_next = RS_HALT;
                    cause_next = HC_BP;
                end else if (cmd_stop) begin
                    state_next = RS_HALT;
                    cause_next = HC_STOP;
                end
            end
            RS_STEP: begin
                tmr_next = tmr_reg - TMR_ONE;
                if (hit) begin
                    state_next = RS_HALT;
                    cause_next = HC_BP;
                end else if (cmd_stop) begin
                    state_next = RS_HALT;
                    cause_next = HC_STOP;
                end else if (commit_v || (tmr_reg == TMR_ONE)) begin
                    // Timer at one means this is the last permitted STEP cycle.
                    state_next = RS_HALT;
                    cause_next = HC_STEP;
                end
            end
            default: begin
                state_next = RS_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RS_HALT;
            cause_reg    <= HC_NONE;
            tmr_reg      <= '0;
            cpu_en_reg   <= 1'b0;
            reach_bp_reg <= 1'b0;
            halt_pc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cause_reg    <= cause_next;
            tmr_reg      <= tmr_next;
            cpu_en_reg   <= (state_next != RS_HALT);
            reach_bp_reg <= hit;
            if (commit_v) begin
                halt_pc_reg <= cpu_pc;
            end
        end
    end

    bp_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (cpu_en_reg),
        .cnt (cycle_cnt)
    );

    bp_sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (commit_v),
        .cnt (inst_cnt)
    );

    assign cpu_en     = cpu_en_reg;
    assign reach_bp   = reach_bp_reg;
    assign run_state  = state_reg;
    assign halt_pc    = halt_pc_reg;
    assign halt_cause = cause_reg;

endmodule

// File: tb/tb_bp_run_ctrl.sv
// Bench for bp_run_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_bp_run_ctrl;

    localparam int TO   = 16;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_stop = 1'b0, cpu_commit = 1'b0;
    logic [31:0]   cpu_pc = '0, bp_0 = '0;
    logic [2:0]    bp_valid = '0;
    logic          cpu_en, reach_bp;
    logic [1:0]    run_state, halt_cause;
    logic [31:0]   halt_pc;
    logic [CW-1:0] cycle_cnt, inst_cnt;

    always #5 clk = ~clk;

    bp_run_ctrl #(.STEP_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_stop   (cmd_stop),
        .cpu_commit (cpu_commit),
        .cpu_pc     (cpu_pc),
        .bp_0       (bp_0),
        .bp_valid   (bp_valid),
        .cpu_en     (cpu_en),
        .reach_bp   (reach_bp),
        .run_state  (run_state),
        .halt_pc    (halt_pc),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .inst_cnt   (inst_cnt)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: mode 0 halted, 1 running, 2 stepping.
    int          m_mode, m_left, m_cyc, m_inst, m_cause;
    logic [31:0] m_pc;
    bit          m_reach;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cyc = 0; m_inst = 0; m_cause = 0;
        m_pc = '0; m_reach = 1'b0;
    endtask

    task automatic check_all(input string where);
        check_val({where, ".cpu_en"},     32'(cpu_en),     32'(m_mode != 0));
        check_val({where, ".reach_bp"},   32'(reach_bp),   32'(m_reach));
        check_val({where, ".run_state"},  32'(run_state),  32'(m_mode));
        check_val({where, ".halt_pc"},    halt_pc,         m_pc);
        check_val({where, ".halt_cause"}, 32'(halt_cause), 32'(m_cause));
        check_val({where, ".cycle_cnt"},  32'(cycle_cnt),  32'(m_cyc));
        check_val({where, ".inst_cnt"},   32'(inst_cnt),   32'(m_inst));
    endtask

    // Apply one cycle of inputs at a falling edge, advance the model, check at the next falling edge.
    task automatic tick(input string where, input bit r, input bit s, input bit p, input bit c,
                        input logic [31:0] pc, input logic [31:0] b0, input logic [2:0] bv);
        bit en, cv, hit;
        cmd_run = r; cmd_step = s; cmd_stop = p; cpu_commit = c;
        cpu_pc = pc; bp_0 = b0; bp_valid = bv;
        en  = (m_mode != 0);
        cv  = c && en;
        hit = cv && bv[0] && (pc == b0);
        if (en && m_cyc < CMAX) m_cyc++;
        if (cv && m_inst < CMAX) m_inst++;
        if (cv) m_pc = pc;
        m_reach = hit;
        if (m_mode == 0) begin
            if (r || s) begin
                m_mode = r ? 1 : 2;
                m_cyc = 0; m_inst = 0; m_cause = 0; m_left = TO;
            end
        end else begin
            if (m_mode == 2) m_left--;
            if (hit) begin
                m_mode = 0; m_cause = 1;
            end else if (p) begin
                m_mode = 0; m_cause = 2;
            end else if (m_mode == 2 && (cv || m_left == 0)) begin
                m_mode = 0; m_cause = 3;
            end
        end
        @(negedge clk);
        check_all(where);
    endtask

    task automatic idle(input string where, input logic [31:0] b0, input logic [2:0] bv);
        tick(where, 0, 0, 0, 0, 32'h0, b0, bv);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        $display("txn: halt idle with ignored commits");
        for (int i = 0; i < 10; i++)
            tick("idle", 0, 0, 1, 1, 32'h10, 32'h10, 3'b001);

        $display("txn: run to breakpoint 0x10");
        tick("bp_run", 1, 0, 0, 0, 32'h0, 32'h10, 3'b001);
        for (int i = 0; i <= 4; i++)
            tick("bp_commit", 0, 0, 0, 1, 32'(i * 4), 32'h10, 3'b001);
        check_val("bp.cpu_en", 32'(cpu_en), 32'h0);
        check_val("bp.reach_bp", 32'(reach_bp), 32'h1);
        check_val("bp.halt_pc", halt_pc, 32'h10);
        check_val("bp.cause", 32'(halt_cause), 32'h1);
        check_val("bp.inst_cnt", 32'(inst_cnt), 32'h5);
        idle("bp_after", 32'h18, 3'b001);
        check_val("bp.reach_pulse", 32'(reach_bp), 32'h0);

        $display("txn: single step commits 0x14");
        tick("step_cmd", 0, 1, 0, 0, 32'h0, 32'h18, 3'b001);
        idle("step_c1", 32'h18, 3'b001);
        tick("step_c2", 0, 0, 0, 1, 32'h14, 32'h18, 3'b001);
        check_val("step.halt_pc", halt_pc, 32'h14);
        check_val("step.cause", 32'(halt_cause), 32'h3);
        check_val("step.inst_cnt", 32'(inst_cnt), 32'h1);
        check_val("step.cycle_cnt", 32'(cycle_cnt), 32'h2);

        $display("txn: step timeout");
        tick("to_cmd", 0, 1, 0, 0, 32'h0, 32'h18, 3'b001);
        for (int i = 0; i < TO; i++) idle("to_wait", 32'h18, 3'b001);
        check_val("to.run_state", 32'(run_state), 32'h0);
        check_val("to.cause", 32'(halt_cause), 32'h3);
        check_val("to.halt_pc", halt_pc, 32'h14);
        check_val("to.inst_cnt", 32'(inst_cnt), 32'h0);
        check_val("to.cycle_cnt", 32'(cycle_cnt), 32'(TO));

        $display("txn: hit beats stop");
        tick("hs_run", 1, 0, 0, 0, 32'h0, 32'h40, 3'b001);
        tick("hs_both", 0, 0, 1, 1, 32'h40, 32'h40, 3'b001);
        check_val("hs.cause", 32'(halt_cause), 32'h1);
        check_val("hs.reach_bp", 32'(reach_bp), 32'h1);

        $display("txn: invalid breakpoint then stop");
        tick("nv_run", 1, 0, 0, 0, 32'h0, 32'h40, 3'b000);
        for (int i = 0; i < 3; i++) tick("nv_commit", 0, 0, 0, 1, 32'h40, 32'h40, 3'b110);
        check_val("nv.cpu_en", 32'(cpu_en), 32'h1);
        tick("nv_stop", 0, 0, 1, 0, 32'h0, 32'h40, 3'b000);
        check_val("nv.cause", 32'(halt_cause), 32'h2);
        check_val("nv.reach_bp", 32'(reach_bp), 32'h0);

        $display("txn: counter saturation");
        tick("sat_run", 1, 0, 0, 0, 32'h0, 32'h40, 3'b001);
        for (int i = 0; i < CMAX + 8; i++) tick("sat_commit", 0, 0, 0, 1, 32'h80, 32'h40, 3'b001);
        tick("sat_stop", 0, 0, 1, 0, 32'h0, 32'h40, 3'b001);
        check_val("sat.cycle_cnt", 32'(cycle_cnt), 32'(CMAX));
        check_val("sat.inst_cnt", 32'(inst_cnt), 32'(CMAX));

        $display("txn: random traffic");
        for (int i = 0; i < 3000; i++) begin
            tick("rand",
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 7)) << 2, 32'($urandom_range(0, 7)) << 2,
                 3'($urandom_range(0, 7)));
        end

        $display("txn: async reset mid-run");
        tick("ar_run", 1, 0, 0, 0, 32'h0, 32'h40, 3'b001);
        tick("ar_commit", 0, 0, 0, 1, 32'h100, 32'h40, 3'b001);
        idle("ar_idle", 32'h40, 3'b001);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("ar.cpu_en", 32'(cpu_en), 32'h0);
        check_val("ar.run_state", 32'(run_state), 32'h0);
        model_reset();
        @(negedge clk);
        check_all("ar_held");
        rst = 1'b1;
        idle("ar_release", 32'h40, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
